// File: rtl/drac_pkg.sv
// Shared definitions for the exe->wb result path: sizing constants, source index map
// and the scalar result record carried from the execution units to writeback.
package drac_pkg;

    localparam int WB_NUM_SRC    = 4;
    localparam int WB_NUM_PORTS  = 2;
    localparam int WB_FIFO_DEPTH = 4;
    localparam int WB_SKID       = 2;

    typedef enum logic [1:0] {
        WB_SRC_ALU = 2'd0,
        WB_SRC_MUL = 2'd1,
        WB_SRC_DIV = 2'd2,
        WB_SRC_MEM = 2'd3
    } wb_src_t;

    typedef struct packed {
        logic        valid;
        logic [39:0] pc;
        logic [4:0]  rd;
        logic [6:0]  prd;
        logic [63:0] result;
        logic        regfile_we;
        logic        ex_valid;
    } exe_wb_scalar_instr_t;

endpackage

// File: rtl/wb_src_fifo.sv
// Per-source result FIFO. Extra pointer MSB separates full from empty; a push into a
// full FIFO is only accepted when the head leaves in the same cycle.
module wb_src_fifo
    import drac_pkg::*;
#(
    parameter int DEPTH = WB_FIFO_DEPTH,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic                 clk_i,
    input  logic                 rstn_i,
    input  logic                 flush,
    input  logic                 push,
    input  logic                 pop,
    input  exe_wb_scalar_instr_t data,
    output exe_wb_scalar_instr_t head,
    output logic                 empty,
    output logic [CNT_W-1:0]     count,
    output logic                 overflow
);

    localparam int IDX_W = CNT_W - 1;

    logic [CNT_W-1:0]     wr_ptr_r;
    logic [CNT_W-1:0]     rd_ptr_r;
    exe_wb_scalar_instr_t mem_r [DEPTH];
    logic                 full_s;
    logic                 empty_s;
    logic                 push_s;
    logic                 pop_s;

    assign empty_s  = (wr_ptr_r == rd_ptr_r);
    assign full_s   = (wr_ptr_r[IDX_W] != rd_ptr_r[IDX_W]) &&
                      (wr_ptr_r[IDX_W-1:0] == rd_ptr_r[IDX_W-1:0]);
    assign pop_s    = pop && !flush && !empty_s;
    assign push_s   = push && !flush && (!full_s || pop_s);
    assign overflow = push && !flush && full_s && !pop_s;

    assign empty = empty_s;
    assign count = wr_ptr_r - rd_ptr_r;
    assign head  = mem_r[rd_ptr_r[IDX_W-1:0]];

    // Read/write pointer update; flush returns both to the empty state.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
        end else if (flush) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + CNT_W'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + CNT_W'(1);
            end
        end
    end

    // Entry storage; the slot being overwritten on full+pop is the head leaving this cycle.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            for (int j = 0; j < DEPTH; j++) begin
                mem_r[j] <= '0;
            end
        end else if (push_s) begin
            mem_r[wr_ptr_r[IDX_W-1:0]] <= data;
        end
    end

endmodule

// File: rtl/exe_wb_arbiter.sv
// Collects results from the non-stallable execution units into per-source FIFOs and
// drains them round-robin onto the register-file write ports.
module exe_wb_arbiter
    import drac_pkg::*;
#(
    parameter int NUM_SRC    = WB_NUM_SRC,
    parameter int NUM_PORTS  = WB_NUM_PORTS,
    parameter int FIFO_DEPTH = WB_FIFO_DEPTH,
    parameter int SKID       = WB_SKID
) (
    input  logic                 clk_i,
    input  logic                 rstn_i,
    input  logic                 flush_i,
    input  exe_wb_scalar_instr_t src_i [NUM_SRC],
    output logic [NUM_SRC-1:0]   stall_o,
    output exe_wb_scalar_instr_t wb_o [NUM_PORTS],
    output logic                 overflow_o
);

    localparam int SRC_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    // Stall once free entries drop to the number of results still in flight.
    localparam logic [CNT_W-1:0] STALL_LEVEL = CNT_W'(FIFO_DEPTH - SKID);

    exe_wb_scalar_instr_t head_s [NUM_SRC];
    logic [CNT_W-1:0]     count_s [NUM_SRC];
    logic [NUM_SRC-1:0]   empty_s;
    logic [NUM_SRC-1:0]   pop_s;
    logic [NUM_SRC-1:0]   drop_s;
    logic [SRC_W-1:0]     rr_ptr_r;
    logic [SRC_W-1:0]     rr_next_s;
    logic [SRC_W-1:0]     last_s;
    logic [SRC_W-1:0]     port_src_s [NUM_PORTS];
    logic [NUM_PORTS-1:0] port_vld_s;
    logic                 overflow_r;

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
        wb_src_fifo #(
            .DEPTH (FIFO_DEPTH)
        ) u_fifo (
            .clk_i    (clk_i),
            .rstn_i   (rstn_i),
            .flush    (flush_i),
            .push     (src_i[i].valid),
            .pop      (pop_s[i]),
            .data     (src_i[i]),
            .head     (head_s[i]),
            .empty    (empty_s[i]),
            .count    (count_s[i]),
            .overflow (drop_s[i])
        );

        assign stall_o[i] = (count_s[i] >= STALL_LEVEL);
    end

    // Round-robin scan from rr_ptr: the k-th non-empty source found owns port k.
    always_comb begin
        int               n_grant;
        int               pos;
        logic             take;
        logic             port_hit;
        logic [SRC_W-1:0] idx;

        pop_s      = '0;
        port_vld_s = '0;
        last_s     = rr_ptr_r;
        n_grant    = 0;
        pos        = 0;
        take       = 1'b0;
        port_hit   = 1'b0;
        idx        = '0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            port_src_s[k] = '0;
        end

        for (int off = 0; off < NUM_SRC; off++) begin
            pos        = int'(rr_ptr_r) + off;
            pos        = (pos >= NUM_SRC) ? (pos - NUM_SRC) : pos;
            idx        = SRC_W'(pos);
            take       = !flush_i && !empty_s[idx] && (n_grant < NUM_PORTS);
            pop_s[idx] = take;
            for (int k = 0; k < NUM_PORTS; k++) begin
                port_hit      = take && (n_grant == k);
                port_vld_s[k] = port_vld_s[k] | port_hit;
                port_src_s[k] = port_hit ? idx : port_src_s[k];
            end
            last_s  = take ? idx : last_s;
            n_grant = n_grant + (take ? 1 : 0);
        end

        if (n_grant == 0) begin
            rr_next_s = rr_ptr_r;
        end else if (int'(last_s) == NUM_SRC - 1) begin
            rr_next_s = '0;
        end else begin
            rr_next_s = last_s + SRC_W'(1);
        end
    end

    // Port mux: granted FIFO head passes through untouched, idle ports are all-zero.
    always_comb begin
        for (int k = 0; k < NUM_PORTS; k++) begin
            wb_o[k] = port_vld_s[k] ? head_s[port_src_s[k]] : '0;
        end
    end

    // Round-robin pointer and one-cycle dropped-push flag.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            rr_ptr_r   <= '0;
            overflow_r <= 1'b0;
        end else begin
            rr_ptr_r   <= rr_next_s;
            overflow_r <= |drop_s;
        end
    end

    assign overflow_o = overflow_r;

endmodule

// File: tb/tb_exe_wb_arbiter.sv
// Directed bench: a 2-port arbiter for ordering/flush/reset and a 1-port arbiter
// for stall, overflow and drain order.
module tb_exe_wb_arbiter;
    import drac_pkg::*;

    logic                     clk;
    logic                     rstn;
    logic                     flush_a;
    logic                     flush_b;
    exe_wb_scalar_instr_t     src_a [WB_NUM_SRC];
    exe_wb_scalar_instr_t     wb_a  [WB_NUM_PORTS];
    exe_wb_scalar_instr_t     src_b [WB_NUM_SRC];
    exe_wb_scalar_instr_t     wb_b  [1];
    logic [WB_NUM_SRC-1:0]    stall_a;
    logic [WB_NUM_SRC-1:0]    stall_b;
    logic                     ovf_a;
    logic                     ovf_b;
    int                       tests;
    int                       fails;
    exe_wb_scalar_instr_t     mul_res;

    // 1-port instance tables, cycle 1..20 (hand-derived push masks and expectations).
    localparam logic [3:0] B_PUSH  [20] = '{4'b1111, 4'b1111, 4'b1111, 4'b1111, 4'b0010,
                                            4'b0010, 4'b0010, 4'b0000, 4'b0000, 4'b0000,
                                            4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000,
                                            4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
    localparam logic [3:0] B_STALL [20] = '{4'b0000, 4'b0000, 4'b1110, 4'b1111, 4'b1111,
                                            4'b1111, 4'b1111, 4'b1111, 4'b1111, 4'b1111,
                                            4'b1110, 4'b1110, 4'b1010, 4'b0010, 4'b0010,
                                            4'b0010, 4'b0010, 4'b0010, 4'b0000, 4'b0000};
    localparam int         B_PRD   [20] = '{0, 1, 17, 33, 49, 2, 18, 34, 50, 3,
                                            19, 35, 51, 4, 20, 36, 52, 21, 23, 0};
    localparam logic       B_OVF   [20] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1,
                                            1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                                            1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

    exe_wb_arbiter u_dut_a (
        .clk_i      (clk),
        .rstn_i     (rstn),
        .flush_i    (flush_a),
        .src_i      (src_a),
        .stall_o    (stall_a),
        .wb_o       (wb_a),
        .overflow_o (ovf_a)
    );

    exe_wb_arbiter #(
        .NUM_PORTS (1)
    ) u_dut_b (
        .clk_i      (clk),
        .rstn_i     (rstn),
        .flush_i    (flush_b),
        .src_i      (src_b),
        .stall_o    (stall_b),
        .wb_o       (wb_b),
        .overflow_o (ovf_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Result tag: prd = src*16 + seq, result = src*4096 + seq.
    function automatic exe_wb_scalar_instr_t mk(input int s, input int c);
        exe_wb_scalar_instr_t r;
        r            = '0;
        r.valid      = 1'b1;
        r.pc         = 40'(c * 4);
        r.rd         = 5'(c);
        r.prd        = 7'(s * 16 + c);
        r.result     = 64'(s * 4096 + c);
        r.regfile_we = 1'b1;
        return r;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_port_a(input string tag, input int k, input exe_wb_scalar_instr_t e);
        chk({tag, "_vld"}, 64'(wb_a[k].valid), 64'(e.valid));
        if (e.valid) begin
            chk({tag, "_prd"}, 64'(wb_a[k].prd), 64'(e.prd));
            chk({tag, "_res"}, wb_a[k].result, e.result);
        end
    endtask

    task automatic clear_a();
        for (int s = 0; s < WB_NUM_SRC; s++) src_a[s] = '0;
    endtask

    initial begin
        tests   = 0;
        fails   = 0;
        rstn    = 1'b0;
        flush_a = 1'b0;
        flush_b = 1'b0;
        clear_a();
        for (int s = 0; s < WB_NUM_SRC; s++) src_b[s] = '0;

        // Reset state
        @(negedge clk); #1;
        chk("rst_a_wb0_vld", 64'(wb_a[0].valid), 64'd0);
        chk("rst_a_wb1_vld", 64'(wb_a[1].valid), 64'd0);
        chk("rst_a_stall", 64'(stall_a), 64'd0);
        chk("rst_a_ovf", 64'(ovf_a), 64'd0);
        chk("rst_b_wb0_vld", 64'(wb_b[0].valid), 64'd0);
        chk("rst_b_ovf", 64'(ovf_b), 64'd0);
        @(negedge clk);
        rstn = 1'b1;

        // 1-port instance: stall rise at count 2, skid pushes, overflow, full+push+pop, drain order
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            for (int s = 0; s < WB_NUM_SRC; s++) src_b[s] = B_PUSH[c-1][s] ? mk(s, c) : '0;
            #1;
            chk($sformatf("b_stall_c%0d", c), 64'(stall_b), 64'(B_STALL[c-1]));
            chk($sformatf("b_ovf_c%0d", c), 64'(ovf_b), 64'(B_OVF[c-1]));
            chk($sformatf("b_vld_c%0d", c), 64'(wb_b[0].valid), 64'(B_PRD[c-1] != 0));
            if (B_PRD[c-1] != 0) begin
                chk($sformatf("b_prd_c%0d", c), 64'(wb_b[0].prd), 64'(B_PRD[c-1]));
                chk($sformatf("b_res_c%0d", c), wb_b[0].result,
                    64'((B_PRD[c-1] / 16) * 4096 + (B_PRD[c-1] % 16)));
            end
        end
        @(negedge clk);
        for (int s = 0; s < WB_NUM_SRC; s++) src_b[s] = '0;

        // All four sources at once, rr_ptr=0: src0/src1 then src2/src3
        @(negedge clk);
        for (int s = 0; s < WB_NUM_SRC; s++) src_a[s] = mk(s, 1);
        #1;
        chk("all4_no_comb_path", 64'(wb_a[0].valid), 64'd0);
        @(negedge clk);
        clear_a();
        #1;
        chk_port_a("all4_t1_p0", 0, mk(0, 1));
        chk_port_a("all4_t1_p1", 1, mk(1, 1));
        chk("all4_t1_stall", 64'(stall_a), 64'd0);
        @(negedge clk); #1;
        chk_port_a("all4_t2_p0", 0, mk(2, 1));
        chk_port_a("all4_t2_p1", 1, mk(3, 1));
        @(negedge clk); #1;
        chk("all4_t3_p0_vld", 64'(wb_a[0].valid), 64'd0);
        chk("all4_t3_p1_vld", 64'(wb_a[1].valid), 64'd0);

        // Single MUL result prd=7 result=0x2A
        @(negedge clk);
        mul_res        = '0;
        mul_res.valid  = 1'b1;
        mul_res.prd    = 7'd7;
        mul_res.result = 64'h2A;
        src_a[int'(WB_SRC_MUL)] = mul_res;
        #1;
        chk("mul_same_cycle_vld", 64'(wb_a[0].valid), 64'd0);
        @(negedge clk);
        clear_a();
        #1;
        chk_port_a("mul_p0", 0, mul_res);
        chk("mul_p1_vld", 64'(wb_a[1].valid), 64'd0);

        // Flush with two buffered entries plus a new push (rr_ptr is 2 here)
        @(negedge clk);
        src_a[2] = mk(2, 5);
        src_a[3] = mk(3, 5);
        @(negedge clk);
        clear_a();
        src_a[1] = mk(1, 6);
        flush_a  = 1'b1;
        #1;
        chk("flush_p0_vld", 64'(wb_a[0].valid), 64'd0);
        chk("flush_p1_vld", 64'(wb_a[1].valid), 64'd0);
        @(negedge clk);
        flush_a = 1'b0;
        clear_a();
        #1;
        chk("flush_next_p0_vld", 64'(wb_a[0].valid), 64'd0);
        chk("flush_next_p1_vld", 64'(wb_a[1].valid), 64'd0);
        chk("flush_next_stall", 64'(stall_a), 64'd0);
        @(negedge clk); #1;
        chk("flush_later_p0_vld", 64'(wb_a[0].valid), 64'd0);

        // rr_ptr kept across flush: scan starts at src2
        @(negedge clk);
        for (int s = 0; s < WB_NUM_SRC; s++) src_a[s] = mk(s, 7);
        @(negedge clk);
        clear_a();
        #1;
        chk_port_a("rr_kept_t1_p0", 0, mk(2, 7));
        chk_port_a("rr_kept_t1_p1", 1, mk(3, 7));
        @(negedge clk); #1;
        chk_port_a("rr_kept_t2_p0", 0, mk(0, 7));
        chk_port_a("rr_kept_t2_p1", 1, mk(1, 7));

        // Reset mid-stream with three entries buffered (rr_ptr is 2)
        @(negedge clk);
        src_a[0] = mk(0, 8);
        src_a[1] = mk(1, 8);
        src_a[2] = mk(2, 8);
        #1;
        chk("pre_rst_p0_vld", 64'(wb_a[0].valid), 64'd0);
        @(negedge clk);
        clear_a();
        #1;
        chk_port_a("pre_rst_p0", 0, mk(2, 8));
        chk_port_a("pre_rst_p1", 1, mk(0, 8));
        rstn = 1'b0;
        #1;
        chk("midrst_p0_vld", 64'(wb_a[0].valid), 64'd0);
        chk("midrst_p1_vld", 64'(wb_a[1].valid), 64'd0);
        chk("midrst_stall", 64'(stall_a), 64'd0);
        chk("midrst_ovf", 64'(ovf_a), 64'd0);
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        src_a[1] = mk(1, 9);
        #1;
        chk("post_rst_push_p0_vld", 64'(wb_a[0].valid), 64'd0);
        @(negedge clk);
        clear_a();
        #1;
        chk_port_a("post_rst_p0", 0, mk(1, 9));
        chk("post_rst_p1_vld", 64'(wb_a[1].valid), 64'd0);
        @(negedge clk); #1;
        chk("post_rst_drained_p0", 64'(wb_a[0].valid), 64'd0);
        chk("post_rst_drained_p1", 64'(wb_a[1].valid), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
